// File: rtl/eq_band_mixer_pkg.sv
// Shared widths, FSM state type and helpers for the EQ band mixer slice.
package eq_mix_pkg;

  localparam int unsigned FIR_W      = 48;
  localparam int unsigned DATA_W     = 24;
  localparam int unsigned GAIN_W     = 8;
  localparam int unsigned GAIN_UNITY = 128;
  localparam int unsigned ACC_W      = 59;
  localparam int unsigned PROD_W     = FIR_W + GAIN_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND,
    OUT
  } eq_mix_state_e;

  // Magnitude of a Q1.23 sample; the most negative code clamps to full scale.
  function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (v == {1'b1, {(DATA_W-1){1'b0}}})
      r = {1'b0, {(DATA_W-1){1'b1}}};
    else if (v[DATA_W-1])
      r = (~v) + 1'b1;
    else
      r = v;
    return r;
  endfunction

endpackage

// File: rtl/eq_band_mixer_if.sv
// Sample/result bus of the EQ band mixer; peak ports exist only with EQ_MIX_PEAK_DET_EN.
interface eq_band_mixer_if
  import eq_mix_pkg::*;
#(
  parameter int unsigned NUM_BANDS = 4
);
  logic                                in_valid;
  logic [NUM_BANDS-1:0][FIR_W-1:0]     l_data_in;
  logic [NUM_BANDS-1:0][FIR_W-1:0]     r_data_in;
  logic [NUM_BANDS-1:0][GAIN_W-1:0]    band_gain;
  logic [NUM_BANDS-1:0]                band_en;
  logic                                out_ready;
  logic                                out_valid;
  logic [DATA_W-1:0]                   l_out;
  logic [DATA_W-1:0]                   r_out;
  logic                                overrun;
  logic                                clip;
  logic                                flags_clr;
`ifdef EQ_MIX_PEAK_DET_EN
  logic                                peak_clr;
  logic [DATA_W-1:0]                   l_peak;
  logic [DATA_W-1:0]                   r_peak;
`endif

  modport master (
    output in_valid, l_data_in, r_data_in, band_gain, band_en, out_ready, flags_clr,
`ifdef EQ_MIX_PEAK_DET_EN
    output peak_clr,
    input  l_peak, r_peak,
`endif
    input  out_valid, l_out, r_out, overrun, clip
  );

  modport slave (
    input  in_valid, l_data_in, r_data_in, band_gain, band_en, out_ready, flags_clr,
`ifdef EQ_MIX_PEAK_DET_EN
    input  peak_clr,
    output l_peak, r_peak,
`endif
    output out_valid, l_out, r_out, overrun, clip
  );

endinterface

// File: rtl/eq_sat_round.sv
// Round-half-up, arithmetic shift and saturation of one channel accumulator to Q1.23.
module eq_sat_round
  import eq_mix_pkg::*;
#(
  parameter int unsigned OUT_SHIFT = 15
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic [DATA_W-1:0]       o_sample,
  output logic                    o_sat
);

  logic signed [ACC_W-1:0]  w_half;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_shift;
  logic [ACC_W-DATA_W:0]    w_hi;

  assign w_half  = ACC_W'(1) << (OUT_SHIFT + 6);
  assign w_sum   = i_acc + w_half;
  assign w_shift = w_sum >>> (OUT_SHIFT + 7);
  // In range only when the sign bit of the 24-bit result is replicated above it.
  assign w_hi    = w_shift[ACC_W-1:DATA_W-1];

  always_comb begin
    o_sat = !((&w_hi) || (~|w_hi));
    if (o_sat)
      o_sample = w_shift[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      o_sample = w_shift[DATA_W-1:0];
  end

endmodule

// File: rtl/eq_band_mixer.sv
// Stereo EQ band mixer: gain-weighted sum of per-band FIR results, one band per cycle.
// Optional peak detector enabled by EQ_MIX_PEAK_DET_EN.
module eq_band_mixer
  import eq_mix_pkg::*;
#(
  parameter int unsigned NUM_BANDS = 4,
  parameter int unsigned OUT_SHIFT = 15
) (
  input  logic           clk,
  input  logic           reset,
  eq_band_mixer_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

  eq_mix_state_e                    r_state;
  logic [IDX_W-1:0]                 r_idx;
  logic [NUM_BANDS-1:0][FIR_W-1:0]  r_l_data;
  logic [NUM_BANDS-1:0][FIR_W-1:0]  r_r_data;
  logic [NUM_BANDS-1:0][GAIN_W-1:0] r_gain;
  logic [NUM_BANDS-1:0]             r_en;
  logic signed [ACC_W-1:0]          r_l_acc;
  logic signed [ACC_W-1:0]          r_r_acc;
  logic                             r_out_valid;
  logic [DATA_W-1:0]                r_l_out;
  logic [DATA_W-1:0]                r_r_out;
  logic                             r_overrun;
  logic                             r_clip;

  logic signed [PROD_W-1:0]         w_l_dx, w_r_dx, w_gx;
  logic signed [PROD_W-1:0]         w_l_prod, w_r_prod;
  logic signed [ACC_W-1:0]          w_l_term, w_r_term;
  logic [DATA_W-1:0]                w_l_sample, w_r_sample;
  logic                             w_l_sat, w_r_sat;
  logic                             w_accept, w_drop, w_sat_evt;

  assign w_l_dx   = {{(PROD_W-FIR_W){r_l_data[r_idx][FIR_W-1]}}, r_l_data[r_idx]};
  assign w_r_dx   = {{(PROD_W-FIR_W){r_r_data[r_idx][FIR_W-1]}}, r_r_data[r_idx]};
  assign w_gx     = {{(PROD_W-GAIN_W){1'b0}}, r_gain[r_idx]};
  assign w_l_prod = w_l_dx * w_gx;
  assign w_r_prod = w_r_dx * w_gx;
  assign w_l_term = r_en[r_idx] ? {{(ACC_W-PROD_W){w_l_prod[PROD_W-1]}}, w_l_prod} : '0;
  assign w_r_term = r_en[r_idx] ? {{(ACC_W-PROD_W){w_r_prod[PROD_W-1]}}, w_r_prod} : '0;

  eq_sat_round #(.OUT_SHIFT(OUT_SHIFT)) u_round_l (
    .i_acc(r_l_acc), .o_sample(w_l_sample), .o_sat(w_l_sat)
  );
  eq_sat_round #(.OUT_SHIFT(OUT_SHIFT)) u_round_r (
    .i_acc(r_r_acc), .o_sample(w_r_sample), .o_sat(w_r_sat)
  );

  // A sample is taken in IDLE, or in OUT when the held result is consumed the same cycle.
  always_comb begin
    w_accept  = bus.in_valid && ((r_state == IDLE) || ((r_state == OUT) && bus.out_ready));
    w_drop    = bus.in_valid && !w_accept;
    w_sat_evt = (r_state == ROUND) && (w_l_sat || w_r_sat);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_l_data    <= '0;
      r_r_data    <= '0;
      r_gain      <= '0;
      r_en        <= '0;
      r_l_acc     <= '0;
      r_r_acc     <= '0;
      r_out_valid <= 1'b0;
      r_l_out     <= '0;
      r_r_out     <= '0;
      r_overrun   <= 1'b0;
      r_clip      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_l_data <= bus.l_data_in;
        r_r_data <= bus.r_data_in;
        r_gain   <= bus.band_gain;
        r_en     <= bus.band_en;
        r_l_acc  <= '0;
        r_r_acc  <= '0;
        r_idx    <= '0;
      end
      case (r_state)
        IDLE: if (w_accept) r_state <= MAC;
        MAC: begin
          r_l_acc <= r_l_acc + w_l_term;
          r_r_acc <= r_r_acc + w_r_term;
          if (r_idx == IDX_W'(NUM_BANDS - 1)) begin
            r_idx   <= '0;
            r_state <= ROUND;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ROUND: begin
          r_l_out     <= w_l_sample;
          r_r_out     <= w_r_sample;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= w_accept ? MAC : IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (bus.flags_clr) begin
        r_overrun <= 1'b0;
        r_clip    <= 1'b0;
      end else begin
        if (w_drop)    r_overrun <= 1'b1;
        if (w_sat_evt) r_clip    <= 1'b1;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.l_out     = r_l_out;
  assign bus.r_out     = r_r_out;
  assign bus.overrun   = r_overrun;
  assign bus.clip      = r_clip;

`ifdef EQ_MIX_PEAK_DET_EN
  logic [DATA_W-1:0] r_l_peak, r_r_peak, w_l_abs, w_r_abs;

  assign w_l_abs = abs_sat(w_l_sample);
  assign w_r_abs = abs_sat(w_r_sample);

  always_ff @(posedge clk) begin
    if (reset || bus.peak_clr) begin
      r_l_peak <= '0;
      r_r_peak <= '0;
    end else if (r_state == ROUND) begin
      if (w_l_abs > r_l_peak) r_l_peak <= w_l_abs;
      if (w_r_abs > r_r_peak) r_r_peak <= w_r_abs;
    end
  end

  assign bus.l_peak = r_l_peak;
  assign bus.r_peak = r_r_peak;
`endif

endmodule

// File: tb/tb_eq_band_mixer.sv
// Directed self-checking bench for eq_band_mixer (default 4 bands, OUT_SHIFT 15).
module tb_eq_band_mixer;
  import eq_mix_pkg::*;

  localparam int unsigned NB = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  eq_band_mixer_if #(.NUM_BANDS(NB)) bus ();

  eq_band_mixer #(.NUM_BANDS(NB), .OUT_SHIFT(15)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic [3:0][47:0]   l;
    logic [3:0][47:0]   r;
    logic [3:0][7:0]    g;
    logic [3:0]         en;
    logic [23:0]        el;
    logic [23:0]        er;
    logic               eclip;
  } vec_t;

  function automatic vec_t mk(input string n,
                              input logic [47:0] l0, l1, l2, l3,
                              input logic [47:0] r0, r1, r2, r3,
                              input logic [7:0] g0, g1, g2, g3,
                              input logic [3:0] en,
                              input logic [23:0] el, er,
                              input logic ec);
    vec_t v;
    v.name = n;
    v.l = {l3, l2, l1, l0};
    v.r = {r3, r2, r1, r0};
    v.g = {g3, g2, g1, g0};
    v.en = en;
    v.el = el;
    v.er = er;
    v.eclip = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic load(input vec_t v);
    bus.l_data_in = v.l;
    bus.r_data_in = v.r;
    bus.band_gain = v.g;
    bus.band_en   = v.en;
  endtask

  task automatic start_sample();
    @(negedge clk); bus.in_valid = 1'b1;
    @(negedge clk); bus.in_valid = 1'b0;
  endtask

  // Counts negedges after the in_valid edge until out_valid; bounded.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic accept();
    @(negedge clk); bus.out_ready = 1'b1;
    @(negedge clk); bus.out_ready = 1'b0;
  endtask

  task automatic clear_flags();
    @(negedge clk); bus.flags_clr = 1'b1;
    @(negedge clk); bus.flags_clr = 1'b0;
  endtask

  vec_t vecs[6];
  vec_t v;
  int   cyc;
  logic seen_valid;

  localparam logic [47:0] D1000 = 48'd32768000;   // 1000 << 15
  localparam logic [47:0] D3    = 48'd49152;      // 3 << 14
  localparam logic [47:0] PMAX  = 48'h7FFF_FFFF_FFFF;
  localparam logic [47:0] NMAX  = 48'h8000_0000_0000;
  localparam logic [7:0]  GU    = 8'(GAIN_UNITY);

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.flags_clr = 1'b0;
    bus.l_data_in = '0;
    bus.r_data_in = '0;
    bus.band_gain = '0;
    bus.band_en   = '0;
`ifdef EQ_MIX_PEAK_DET_EN
    bus.peak_clr = 1'b0;
`endif

    vecs[0] = mk("unity", D1000, 0, 0, 0, 0, 0, 0, 0, GU, GU, GU, GU, 4'hF,
                 24'd1000, 24'd0, 1'b0);
    vecs[1] = mk("neg_round_up", -D1000, 0, 0, 0, D3, 0, 0, 0, GU, GU, GU, GU, 4'hF,
                 24'hFFFC18, 24'd2, 1'b0);
    vecs[2] = mk("neg_half", -D3, 0, 0, 0, 0, 0, 0, 0, GU, GU, GU, GU, 4'hF,
                 24'hFFFFFF, 24'd0, 1'b0);
    vecs[3] = mk("saturate", PMAX, PMAX, PMAX, PMAX, NMAX, NMAX, NMAX, NMAX,
                 8'd255, 8'd255, 8'd255, 8'd255, 4'hF, 24'h7FFFFF, 24'h800000, 1'b1);
    vecs[4] = mk("mute", 48'h1234_5678, D1000, D1000, D1000, D1000, 0, 0, 0,
                 8'd64, 8'd64, 8'd64, 8'd64, 4'b1110, 24'd1500, 24'd0, 1'b0);
    vecs[5] = mk("mixed", 48'd100 << 15, 48'd200 << 15, 48'd400 << 15, 0,
                 0, 0, 0, 48'd128 << 15, GU, 8'd64, 8'd32, 8'd255, 4'hF,
                 24'd300, 24'd255, 1'b0);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 48'(bus.out_valid), 48'd0);
    check("rst_l_out", 48'(bus.l_out), 48'd0);
    check("rst_r_out", 48'(bus.r_out), 48'd0);
    check("rst_overrun", 48'(bus.overrun), 48'd0);
    check("rst_clip", 48'(bus.clip), 48'd0);
`ifdef EQ_MIX_PEAK_DET_EN
    check("rst_l_peak", 48'(bus.l_peak), 48'd0);
`endif

    for (int i = 0; i < 6; i++) begin
      load(vecs[i]);
      start_sample();
      wait_out(cyc);
      check({vecs[i].name, "_latency"}, 48'(cyc + 1), 48'(NB + 2));
      check({vecs[i].name, "_l_out"}, 48'(bus.l_out), 48'(vecs[i].el));
      check({vecs[i].name, "_r_out"}, 48'(bus.r_out), 48'(vecs[i].er));
      check({vecs[i].name, "_clip"}, 48'(bus.clip), 48'(vecs[i].eclip));
      accept();
      check({vecs[i].name, "_valid_drop"}, 48'(bus.out_valid), 48'd0);
      clear_flags();
      check({vecs[i].name, "_clip_clr"}, 48'(bus.clip), 48'd0);
    end

    // Result held while out_ready is low; a second sample is dropped.
    v = mk("one", 48'd32768, 0, 0, 0, 0, 0, 0, 0, GU, GU, GU, GU, 4'hF, 24'd1, 24'd0, 1'b0);
    load(v);
    start_sample();
    wait_out(cyc);
    check("hold_first_l", 48'(bus.l_out), 48'd1);
    bus.l_data_in[0] = D1000;
    @(negedge clk); bus.in_valid = 1'b1;
    @(negedge clk); bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("hold_valid", 48'(bus.out_valid), 48'd1);
    check("hold_l_out", 48'(bus.l_out), 48'd1);
    check("hold_overrun", 48'(bus.overrun), 48'd1);
    accept();
    check("hold_idle_valid", 48'(bus.out_valid), 48'd0);
    clear_flags();
    check("overrun_clr", 48'(bus.overrun), 48'd0);

    // Back-to-back: new sample accepted in the same cycle as out_ready.
    load(v);
    start_sample();
    wait_out(cyc);
    check("b2b_first_l", 48'(bus.l_out), 48'd1);
    bus.l_data_in[0] = D1000;
    @(negedge clk); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk); bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    check("b2b_valid_low", 48'(bus.out_valid), 48'd0);
    wait_out(cyc);
    check("b2b_latency", 48'(cyc + 1), 48'(NB + 2));
    check("b2b_l_out", 48'(bus.l_out), 48'd1000);
    check("b2b_overrun", 48'(bus.overrun), 48'd0);
    accept();

    // Reset in the middle of MAC aborts the sample.
    start_sample();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    seen_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1'b1;
    end
    check("abort_no_valid", 48'(seen_valid), 48'd0);
    check("abort_l_out", 48'(bus.l_out), 48'd0);
    check("abort_r_out", 48'(bus.r_out), 48'd0);

`ifdef EQ_MIX_PEAK_DET_EN
    v = mk("m500", -(48'd500 << 15), 0, 0, 0, 0, 0, 0, 0, GU, GU, GU, GU, 4'hF,
           24'd0, 24'd0, 1'b0);
    load(v);
    start_sample();
    wait_out(cyc);
    check("peak_neg_l_out", 48'(bus.l_out), 48'(24'hFFFE0C));
    accept();
    bus.l_data_in[0] = 48'd300 << 15;
    start_sample();
    wait_out(cyc);
    check("peak_pos_l_out", 48'(bus.l_out), 48'd300);
    accept();
    check("l_peak", 48'(bus.l_peak), 48'd500);
    check("r_peak", 48'(bus.r_peak), 48'd0);
    @(negedge clk); bus.peak_clr = 1'b1;
    @(negedge clk); bus.peak_clr = 1'b0;
    check("l_peak_clr", 48'(bus.l_peak), 48'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eq_band_mixer.md
EQ_BAND_MIXER -- requirements
Module: eq_band_mixer

Interface
REQ-001 SHALL have parameter NUM_BANDS, default 4, number of FIR bands per channel (legal range 1..8).
REQ-002 SHALL have parameter OUT_SHIFT, default 15, right shift that aligns the FIR Q2.38 sum to Q1.23.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, a one-cycle strobe; l_data_in and r_data_in are valid in that cycle.
REQ-006 SHALL have ports l_data_in and r_data_in, inputs, [47:0] x NUM_BANDS, signed per-band FIR results.
REQ-007 SHALL have port band_gain, input, [7:0] x NUM_BANDS, unsigned Q1.7 gain per band; 128 is unity.
REQ-008 SHALL have port band_en, input, NUM_BANDS bits, per-band enable; a 0 bit mutes that band.
REQ-009 SHALL have port out_ready, input, 1 bit, downstream accept.
REQ-010 SHALL have port out_valid, output, 1 bit, asserted while l_out and r_out hold a result.
REQ-011 SHALL have ports l_out and r_out, outputs, 24 bits each, signed Q1.23 mixed samples.
REQ-012 SHALL have port overrun, output, 1 bit, sticky flag set when an input sample is dropped.
REQ-013 SHALL have port clip, output, 1 bit, sticky flag set when either channel saturates.
REQ-014 SHALL have port flags_clr, input, 1 bit, clears overrun and clip.

Function
REQ-015 SHALL run an FSM with states IDLE, MAC, ROUND, OUT.
REQ-016 SHALL, when in_valid is high in IDLE, snapshot all data, band_gain and band_en, clear both accumulators, and go to MAC.
REQ-017 SHALL in MAC process one band per cycle for L and R in parallel: acc += band_en[k] ? data[k]*gain[k] : 0, for k = 0..NUM_BANDS-1 ascending.
REQ-018 SHALL leave MAC after NUM_BANDS cycles and spend exactly 1 cycle in ROUND.
REQ-019 SHALL use signed arithmetic: 48x9-bit products (gain zero-extended) into an accumulator of 56+3 bits that cannot overflow.
REQ-020 SHALL in ROUND add 2^(OUT_SHIFT+6), shift arithmetically right by OUT_SHIFT+7, and saturate to [-2^23, 2^23-1]; this is round-half-up.
REQ-021 SHALL register the rounded results to l_out and r_out and assert out_valid at the start of OUT, which is NUM_BANDS+2 cycles after the in_valid cycle.
REQ-022 SHALL hold out_valid, l_out and r_out stable in OUT until out_ready=1, then return to IDLE.
REQ-023 SHALL treat in_valid together with out_ready in OUT as an accepted new sample, going directly to MAC.
REQ-024 SHALL drop any in_valid that arrives in MAC, in ROUND, or in OUT without out_ready, and set overrun.
REQ-025 SHALL set clip when either channel saturates in ROUND.
REQ-026 SHALL let flags_clr win over a same-cycle set event.
REQ-027 SHALL keep l_out and r_out at their last values outside OUT, and keep out_valid at 0 outside OUT.

Reset
REQ-028 SHALL on reset force the FSM to IDLE, set out_valid, l_out, r_out, overrun, clip and the accumulators to 0, and set the peak registers to 0.
REQ-029 SHALL abort any in-progress sample if reset is asserted mid-MAC or mid-OUT, with no output produced for it.

Configuration
REQ-030 SHALL, with EQ_MIX_PEAK_DET_EN defined, add outputs l_peak and r_peak (24 bits unsigned) that track the maximum |out| of each emitted result, plus a peak_clr input; |-2^23| saturates to 2^23-1.
REQ-031 SHALL, without EQ_MIX_PEAK_DET_EN, omit the peak ports and logic entirely.

Structure
REQ-032 SHALL take FIR_W=48, DATA_W=24, GAIN_W=8, GAIN_UNITY=128, ACC_W=59 and the FSM state enum from a shared package, eq_mix_pkg.
REQ-033 SHALL place round and saturate in one sub-module, eq_sat_round (input: accumulator; outputs: 24-bit sample and sat flag), instantiated once per channel.

Verification
REQ-034 SHALL verify unity gain: l band0 = 1000<<15, gain 128, others 0 -> l_out=1000 with out_valid at cycle NUM_BANDS+2, clip=0.
REQ-035 SHALL verify negative values and rounding, all other bands 0:
- band0 = -(1000<<15) -> 24'hFFFC18.
- band0 = 3<<14 -> 2.
- band0 = -(3<<14) -> -1.
REQ-036 SHALL verify saturation: all 4 bands 48'h7FFF_FFFF_FFFF, gain 255 -> 24'h7FFFFF and clip=1; then flags_clr -> clip=0.
REQ-037 SHALL verify band mute: band_en=4'b1110 with band0 data nonzero -> band0 excluded from the sum; all bands gain 64 with data 1000<<15 -> 1500.
REQ-038 SHALL verify the handshake:
- Hold out_ready=0 while a second in_valid arrives -> result 1 unchanged, overrun=1.
- in_valid coincident with out_ready in OUT -> accepted, next out_valid NUM_BANDS+2 cycles later.
REQ-039 SHALL verify reset mid-MAC -> out_valid stays 0, all outputs 0; with EQ_MIX_PEAK_DET_EN, outputs -500 then 300 -> l_peak=500.
